midi_note_parser: RTL
=====================

// Module: midi_note_parser
// PURPOSE
//  Converts the raw MIDI byte stream from the UART receiver into note_change_t events
//  for the polyphony dispatcher, one event per complete Note On / Note Off message.
//  Handles running status, realtime bytes interleaved mid-message, SysEx / system-common
//  skipping, channel filtering and Note On velocity 0. Sits between the MIDI UART RX and
//  the dispatcher; its note / note_ready outputs connect directly to the dispatcher inputs.
// PARAMETERS
//  CHANNEL      0  MIDI channel (0-15) accepted when OMNI == 0
//  OMNI         0  1: accept note messages on every channel
// PORTS
//  clock_50_000_000  in   1      system clock; the only clock
//  reset             in   1      asynchronous, active-high reset
//  rx_byte           in   8      received MIDI byte
//  rx_valid          in   1      rx_byte valid; one-cycle strobe per byte
//  note              out  $bits(note_change_t)  {status, note_number, velocity}, MIDI:: types
//  note_ready        out  1      one-cycle pulse: note holds a new event
//  parse_error       out  1      one-cycle pulse: malformed stream detected
// BEHAVIOUR
//  Reset: note = {OFF, 0, 0}; note_ready = 0; parse_error = 0; state = IDLE; running status cleared.
//  Byte classes are examined only on cycles with rx_valid = 1:
//   - realtime 0xF8-0xFF: ignored completely; no change to state, running status or data.
//   - channel status 0x80-0xEF: latched as running status; state = DATA1; any partial message dropped.
//     A partial message dropped this way (state DATA2) pulses parse_error.
//   - system common 0xF0-0xF7: clears running status; state = SKIP.
//   - data 0x00-0x7F: consumed according to the current state.
//  States:
//   IDLE  no running status; a data byte pulses parse_error and is discarded.
//   DATA1 a data byte is stored as d1. For 0xCn / 0xDn (one data byte) the message is done: discard, stay DATA1.
//         For every other status: -> DATA2.
//   DATA2 a data byte is stored as d2; the message is complete; -> DATA1 (running status kept).
//   SKIP  data bytes are discarded until the next channel status byte; no errors pulsed.
//  Emission on message completion, only for 0x8n / 0x9n with an accepted channel:
//   - 0x9n, d2 != 0 -> {ON, d1, d2}.
//   - 0x9n, d2 == 0 -> {OFF, d1, 0}.
//   - 0x8n          -> {OFF, d1, d2}; the release velocity passes through.
//   - 0xAn / 0xBn / 0xEn messages, and note messages on rejected channels, are consumed silently.
//  Timing: note and note_ready are registered. note_ready is high the cycle after the rx_valid cycle
//   carrying d2, and for exactly that one cycle. note holds its value until the next emission.
//  Rate: back-to-back rx_valid on consecutive cycles is supported at full rate; there is no backpressure.
//  Reset asserted mid-message: the partial message is lost; no emission after release.
//  Release is synchronous to the clock edge; the first byte after reset is parsed from IDLE.
// TESTING
//  1 Note On: 90 3C 64 -> one cycle after 64, note_ready = 1, note = {ON, 60, 100}; next cycle note_ready = 0.
//  2 Running status: after test 1, send 3E 00 then 3E 40.
//    -> {OFF, 62, 0} pulse, then {ON, 62, 64}.
//  3 Realtime interleave: 90 F8 3C FE 64 -> single {ON, 60, 100}.
//    Timing identical to test 1 relative to the 64 byte.
//  4 Channel filter, CHANNEL = 0, OMNI = 0: 91 3C 64 -> no note_ready. 81 3C 00 -> none.
//    Repeat with OMNI = 1 -> both emitted, the second as {OFF, 60, 0}.
//  5 Errors / skip: after reset, 3C -> parse_error pulse, no note_ready. 90 3C 91 -> parse_error at 91.
//    F0 7E 3C 64 F7 3C 64 -> nothing emitted.
//  6 Mixed / reset: C0 05 3C -> no emission, stays DATA1. B0 07 7F -> none.
//    90 3C, then reset, then 64 -> parse_error, no note.

Source files
------------

// File: rtl/midi_note_parser.sv
// midi_note_parser
//
// Turns the raw MIDI byte stream from the UART receiver into note_change_t
// events for the polyphony dispatcher. One event is produced for each
// complete Note On or Note Off message on an accepted channel. The parser
// handles running status, realtime bytes interleaved inside a message,
// skipping of SysEx and system-common data, channel filtering, and Note On
// messages with velocity 0.
//
// Parameters
//   CHANNEL  MIDI channel (0-15) that is accepted when OMNI is 0
//   OMNI     1: accept note messages on every channel
//
// Ports
//   clock_50_000_000  in   system clock; the only clock
//   reset             in   asynchronous, active-high reset
//   rx_byte           in   received MIDI byte
//   rx_valid          in   one-cycle strobe marking rx_byte as valid
//   note              out  {status, note_number, velocity}; holds the last event
//   note_ready        out  one-cycle pulse: note carries a new event
//   parse_error       out  one-cycle pulse: malformed stream detected

package MIDI;

   typedef enum logic {
      OFF = 1'b0,
      ON  = 1'b1
   } note_status_t;

   typedef struct packed {
      note_status_t status;
      logic [6:0]   note_number;
      logic [6:0]   velocity;
   } note_change_t;

endpackage

module midi_note_parser #(
   parameter logic [3:0] CHANNEL = 4'd0,
   parameter bit         OMNI    = 1'b0
) (
   input  logic               clock_50_000_000,
   input  logic               reset,
   input  logic [7:0]         rx_byte,
   input  logic               rx_valid,
   output MIDI::note_change_t note,
   output logic               note_ready,
   output logic               parse_error
);

   // IDLE  : no running status; stray data bytes are errors
   // DATA1 : waiting for the first data byte of a message
   // DATA2 : waiting for the second data byte of a message
   // SKIP  : inside SysEx / system-common data; discard until a channel status byte
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA1 = 2'd1,
      DATA2 = 2'd2,
      SKIP  = 2'd3
   } parse_state_t;

   localparam logic [3:0] CMD_NOTE_OFF  = 4'h8;
   localparam logic [3:0] CMD_NOTE_ON   = 4'h9;
   localparam logic [3:0] CMD_PROGRAM   = 4'hC;
   localparam logic [3:0] CMD_PRESSURE  = 4'hD;

   parse_state_t state;
   logic [7:0]   running_status;
   logic [6:0]   d1;

   logic         is_realtime;
   logic         is_channel_status;
   logic         is_system_common;
   logic         is_data;
   logic [3:0]   running_cmd;
   logic         single_data_msg;
   logic         channel_accepted;
   logic         is_note_msg;

   // Byte classification and facts about the currently latched running
   // status. Realtime bytes (F8-FF) must be invisible to the parser, so they
   // are separated out before anything else looks at the byte.
   always_comb begin
      is_realtime       = (rx_byte[7:3] == 5'b11111);
      is_system_common  = (rx_byte[7:3] == 5'b11110);
      is_channel_status = rx_byte[7] && (rx_byte[7:4] != 4'hF);
      is_data           = !rx_byte[7];

      running_cmd       = running_status[7:4];
      single_data_msg   = (running_cmd == CMD_PROGRAM) || (running_cmd == CMD_PRESSURE);
      is_note_msg       = (running_cmd == CMD_NOTE_ON) || (running_cmd == CMD_NOTE_OFF);
      channel_accepted  = OMNI || (running_status[3:0] == CHANNEL);
   end

   // Parser state machine. note_ready and parse_error are pulses: they are
   // cleared every cycle and only set on the cycle that detects the event,
   // which makes them valid for exactly the cycle after the triggering byte.
   // Running status is kept after a completed message so that a following
   // pair of data bytes forms another message of the same type.
   always_ff @(posedge clock_50_000_000 or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         running_status <= 8'h00;
         d1             <= 7'd0;
         note           <= '{status: MIDI::OFF, note_number: 7'd0, velocity: 7'd0};
         note_ready     <= 1'b0;
         parse_error    <= 1'b0;
      end else begin
         note_ready  <= 1'b0;
         parse_error <= 1'b0;

         if (rx_valid) begin
            if (is_realtime) begin
               // realtime bytes leave every piece of parser state untouched
            end else if (is_channel_status) begin
               // A new status byte restarts message assembly. Dropping a
               // message that already had its first data byte means the
               // sender broke off mid-message, which is reported.
               running_status <= rx_byte;
               state          <= DATA1;
               if (state == DATA2) begin
                  parse_error <= 1'b1;
               end
            end else if (is_system_common) begin
               running_status <= 8'h00;
               state          <= SKIP;
            end else if (is_data) begin
               case (state)
                  IDLE: begin
                     parse_error <= 1'b1;
                  end

                  DATA1: begin
                     d1 <= rx_byte[6:0];
                     // Program change and channel pressure carry one data
                     // byte; the message is complete and consumed silently.
                     if (!single_data_msg) begin
                        state <= DATA2;
                     end
                  end

                  DATA2: begin
                     state <= DATA1;
                     if (is_note_msg && channel_accepted) begin
                        note_ready       <= 1'b1;
                        note.note_number <= d1;
                        if (running_cmd == CMD_NOTE_ON && rx_byte[6:0] != 7'd0) begin
                           note.status   <= MIDI::ON;
                           note.velocity <= rx_byte[6:0];
                        end else if (running_cmd == CMD_NOTE_ON) begin
                           // Note On with velocity 0 is the common running-status
                           // shorthand for a release.
                           note.status   <= MIDI::OFF;
                           note.velocity <= 7'd0;
                        end else begin
                           // Note Off keeps its release velocity.
                           note.status   <= MIDI::OFF;
                           note.velocity <= rx_byte[6:0];
                        end
                     end
                  end

                  SKIP: begin
                     // SysEx payload and system-common data are discarded
                  end

                  default: begin
                     state <= IDLE;
                  end
               endcase
            end
         end
      end
   end

endmodule
